// File: rtl/fdb_pkg.sv
// Shared types and constants for the fetch/decode instruction buffer.
package fdb_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fdb_entry_t;

endpackage

// File: rtl/fdb_ram.sv
// DEPTH x 64-bit entry store: one synchronous write port, one asynchronous read port.
module fdb_ram
  import fdb_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fdb_entry_t    wdata,
  input  logic [AW-1:0] raddr,
  output fdb_entry_t    rdata
);

  fdb_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_buffer.sv
// Circular instruction queue between fetch and decode with flush and fetch pause.
// Optional zero-latency empty bypass enabled by defining FDB_BYPASS_EN.
module fetch_decode_buffer
  import fdb_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_FDB_valid,
  input  logic [31:0]      i_FDB_inst,
  input  logic [31:0]      i_FDB_PC,
  output logic             o_FDB_pause,
  input  logic             i_FDB_ready,
  input  logic             i_FDB_flush,
  output logic             o_FDB_valid,
  output logic [31:0]      o_FDB_inst,
  output logic [31:0]      o_FDB_PC,
  output logic [CNT_W-1:0] o_FDB_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             wr_en;
  logic             bypass;
  fdb_entry_t       wr_entry;
  fdb_entry_t       head;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push     = i_FDB_valid & ~full & ~i_FDB_flush;
  assign pop      = ~empty & i_FDB_ready & ~i_FDB_flush;
  assign wr_entry = '{pc: i_FDB_PC, inst: i_FDB_inst};

`ifdef FDB_BYPASS_EN
  // An entry taken straight through by decode while empty never touches storage.
  assign bypass = empty & i_FDB_valid & ~i_FDB_flush;
  assign wr_en  = push & ~(bypass & i_FDB_ready);
`else
  assign bypass = 1'b0;
  assign wr_en  = push;
`endif

  fdb_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_comb begin
    o_FDB_valid = 1'b0;
    o_FDB_inst  = NOP_INST;
    o_FDB_PC    = '0;
    if (!empty) begin
      o_FDB_valid = 1'b1;
      o_FDB_inst  = head.inst;
      o_FDB_PC    = head.pc;
    end else if (bypass) begin
      o_FDB_valid = 1'b1;
      o_FDB_inst  = i_FDB_inst;
      o_FDB_PC    = i_FDB_PC;
    end
  end

  // Pause depends on registered occupancy only, so ready never reaches it combinationally.
  assign o_FDB_pause = full;
  assign o_FDB_count = count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_FDB_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(wr_en) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Self-checking bench for fetch_decode_buffer: directed steps plus random traffic against a queue model.
module tb_fetch_decode_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rstn;
  logic             i_FDB_valid;
  logic [31:0]      i_FDB_inst;
  logic [31:0]      i_FDB_PC;
  logic             o_FDB_pause;
  logic             i_FDB_ready;
  logic             i_FDB_flush;
  logic             o_FDB_valid;
  logic [31:0]      o_FDB_inst;
  logic [31:0]      o_FDB_PC;
  logic [CNT_W-1:0] o_FDB_count;

  int unsigned checks;
  int unsigned errors;

  // Model: queue of {pc, inst} in arrival order.
  logic [63:0] q[$];

`ifdef FDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  fetch_decode_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_FDB_valid (i_FDB_valid),
    .i_FDB_inst  (i_FDB_inst),
    .i_FDB_PC    (i_FDB_PC),
    .o_FDB_pause (o_FDB_pause),
    .i_FDB_ready (i_FDB_ready),
    .i_FDB_flush (i_FDB_flush),
    .o_FDB_valid (o_FDB_valid),
    .o_FDB_inst  (o_FDB_inst),
    .o_FDB_PC    (o_FDB_PC),
    .o_FDB_count (o_FDB_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(o_FDB_valid), 32'd0);
    chk({tag, "_pause"}, 32'(o_FDB_pause), 32'd0);
    chk({tag, "_count"}, 32'(o_FDB_count), 32'd0);
    chk({tag, "_inst"},  o_FDB_inst, 32'd0);
    chk({tag, "_pc"},    o_FDB_PC, 32'd0);
  endtask

  // One clock cycle: drive, check outputs mid-cycle against the model, then advance model and clock.
  task automatic cycle(input string tag, input logic v, input logic [31:0] inst,
                       input logic [31:0] pc, input logic rdy, input logic fl);
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    int          sz;
    i_FDB_valid = v;
    i_FDB_inst  = inst;
    i_FDB_PC    = pc;
    i_FDB_ready = rdy;
    i_FDB_flush = fl;
    @(negedge clk);
    sz = q.size();
    e_valid = 1'b0;
    e_inst  = 32'd0;
    e_pc    = 32'd0;
    if (sz > 0) begin
      e_valid = 1'b1;
      e_pc    = q[0][63:32];
      e_inst  = q[0][31:0];
    end else if (BYP && v && !fl) begin
      e_valid = 1'b1;
      e_pc    = pc;
      e_inst  = inst;
    end
    chk({tag, "_valid"}, 32'(o_FDB_valid), 32'(e_valid));
    chk({tag, "_inst"},  o_FDB_inst, e_inst);
    chk({tag, "_pc"},    o_FDB_PC, e_pc);
    chk({tag, "_count"}, 32'(o_FDB_count), 32'(sz));
    chk({tag, "_pause"}, 32'(o_FDB_pause), 32'(sz == DEPTH));
    if (fl) begin
      q.delete();
    end else begin
      if (sz > 0 && rdy) void'(q.pop_front());
      if (v && sz < DEPTH && !(BYP && sz == 0 && rdy)) q.push_back({pc, inst});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rstn        = 1'b0;
    i_FDB_valid = 1'b0;
    i_FDB_inst  = '0;
    i_FDB_PC    = '0;
    i_FDB_ready = 1'b0;
    i_FDB_flush = 1'b0;
    #12;
    chk_idle("reset");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Single push, visible next cycle.
    cycle("t1_push", 1'b1, 32'h2402_0001, 32'h4, 1'b0, 1'b0);
    cycle("t1_out",  1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Fill to DEPTH, fifth valid ignored, one ready pulse releases pause.
    for (int i = 0; i < 3; i++)
      cycle("t2_fill", 1'b1, 32'h1000_0000 + 32'(i), 32'h8 + 32'(4 * i), 1'b0, 1'b0);
    cycle("t2_full", 1'b1, 32'hDEAD_BEEF, 32'h100, 1'b0, 1'b0);
    cycle("t2_pop",  1'b1, 32'hDEAD_BEEF, 32'h100, 1'b1, 1'b0);
    cycle("t2_after", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle("t2_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle("t2_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle("t2_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle("t2_empty", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Streaming push+pop with wrapping pointers.
    cycle("t3_prime", 1'b1, 32'hA000_0000, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++)
      cycle("t3_stream", 1'b1, 32'hA000_0000 + 32'(i), 32'(4 * i), 1'b1, 1'b0);
    cycle("t3_tail", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with count=3 drops everything including the flush-cycle instruction.
    for (int i = 0; i < 3; i++)
      cycle("t4_fill", 1'b1, 32'hB000_0000 + 32'(i), 32'h200 + 32'(4 * i), 1'b0, 1'b0);
    cycle("t4_flush", 1'b1, 32'hBAD0_BAD0, 32'h300, 1'b1, 1'b1);
    cycle("t4_after", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset with count=2.
    cycle("t5_fill", 1'b1, 32'hC000_0001, 32'h400, 1'b0, 1'b0);
    cycle("t5_fill", 1'b1, 32'hC000_0002, 32'h404, 1'b0, 1'b0);
    i_FDB_valid = 1'b0;
    #2;
    chk("t5_pre_count", 32'(o_FDB_count), 32'd2);
    rstn = 1'b0;
    #1;
    chk_idle("t5_rst");
    q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Empty with valid and ready: bypass takes it same cycle, otherwise stored.
    cycle("t6_byp", 1'b1, 32'h0000_0020, 32'h500, 1'b1, 1'b0);
    cycle("t6_after", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle("t6_idle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle("rand", ($urandom_range(0, 9) < 7), $urandom, $urandom,
            ($urandom_range(0, 9) < 5), ($urandom_range(0, 39) == 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
